// File: rtl/tick_scheduler.sv
// Tick prescaler, hh:mm:ss time of day and N_EVT periodic event channels with a
// fixed-priority valid/ready event presenter. Optional alarm via TICK_SCHED_ALARM_EN.
module tick_scheduler #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int ACCEL_FACTOR = 60,
    parameter int N_EVT        = 4,
    parameter int PER_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acelerar,
    input  logic             pause,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_idx,
    input  logic [PER_W-1:0] cfg_period,
    output logic             evt_valid,
    output logic [2:0]       evt_id,
    input  logic             evt_ready,
    output logic             sec_tick,
    output logic             accel_led,
    output logic [4:0]       hh,
    output logic [5:0]       mm,
    output logic [5:0]       ss
`ifdef TICK_SCHED_ALARM_EN
    ,
    input  logic [4:0]       alarm_hh,
    input  logic [5:0]       alarm_mm,
    input  logic             alarm_on,
    output logic             alarm
`endif
);

    localparam int PRE_W = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] LIM_NORM  = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] LIM_ACCEL = PRE_W'(CLK_HZ / ACCEL_FACTOR - 1);

    // Handshake: an event transfers on any edge where evt_valid && evt_ready; while
    // evt_valid=1 and evt_ready=0 the presented evt_id is held stable.

    logic [PRE_W-1:0] presc;
    logic [PRE_W-1:0] lim;
    logic             tick_now;

    assign lim      = accel_led ? LIM_ACCEL : LIM_NORM;
    // A mode toggle restarts the prescaler and suppresses the tick on that edge.
    assign tick_now = !pause && !acelerar && (presc == lim);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            accel_led <= 1'b0;
            sec_tick  <= 1'b0;
        end else begin
            sec_tick <= tick_now;
            if (acelerar) begin
                accel_led <= ~accel_led;
                presc     <= '0;
            end else if (!pause) begin
                presc <= (presc == lim) ? '0 : presc + 1'b1;
            end
        end
    end

    logic [4:0] hh_n;
    logic [5:0] mm_n;
    logic [5:0] ss_n;

    always_comb begin
        ss_n = (ss == 6'd59) ? 6'd0 : ss + 6'd1;
        mm_n = mm;
        hh_n = hh;
        if (ss == 6'd59) begin
            mm_n = (mm == 6'd59) ? 6'd0 : mm + 6'd1;
            if (mm == 6'd59) hh_n = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hh <= 5'd0;
            mm <= 6'd0;
            ss <= 6'd0;
        end else if (tick_now) begin
            hh <= hh_n;
            mm <= mm_n;
            ss <= ss_n;
        end
    end

`ifdef TICK_SCHED_ALARM_EN
    always_ff @(posedge clk) begin
        if (rst) alarm <= 1'b0;
        else     alarm <= tick_now && alarm_on && (hh_n == alarm_hh) &&
                          (mm_n == alarm_mm) && (ss_n == 6'd0);
    end
`endif

    logic [PER_W-1:0] period [N_EVT];
    logic [PER_W-1:0] cnt    [N_EVT];
    logic [N_EVT-1:0] pending;
    logic [N_EVT-1:0] expire;
    logic [N_EVT-1:0] cfg_hit;

    always_comb begin
        expire  = '0;
        cfg_hit = '0;
        for (int k = 0; k < N_EVT; k++) begin
            expire[k]  = tick_now && (period[k] != '0) && (cnt[k] == PER_W'(1));
            cfg_hit[k] = cfg_we && (cfg_idx == 3'(k));
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_EVT; k++) begin
            if (rst) begin
                period[k] <= '0;
                cnt[k]    <= '0;
            end else if (cfg_hit[k]) begin
                period[k] <= cfg_period;
                cnt[k]    <= cfg_period;
            end else if (tick_now && (period[k] != '0)) begin
                cnt[k] <= expire[k] ? period[k] : cnt[k] - 1'b1;
            end
        end
    end

    logic [N_EVT-1:0] pend_n;
    logic             held;
    logic [2:0]       id_n;

    // Priority per channel: configuration write > expiry > transfer clear.
    always_comb begin
        pend_n = pending;
        for (int k = 0; k < N_EVT; k++) begin
            if (evt_valid && evt_ready && (evt_id == 3'(k))) pend_n[k] = 1'b0;
            if (expire[k])  pend_n[k] = 1'b1;
            if (cfg_hit[k]) pend_n[k] = 1'b0;
        end
        held = 1'b0;
        for (int k = 0; k < N_EVT; k++) begin
            if (evt_id == 3'(k)) held = pend_n[k];
        end
        id_n = 3'd0;
        for (int k = N_EVT - 1; k >= 0; k--) begin
            if (pend_n[k]) id_n = 3'(k);
        end
        if (evt_valid && !evt_ready && held) id_n = evt_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            evt_valid <= 1'b0;
            evt_id    <= 3'd0;
        end else begin
            pending   <= pend_n;
            evt_valid <= |pend_n;
            evt_id    <= id_n;
        end
    end

endmodule
